hold_tx: RTL

Transmit-side companion to the hysteresis input filter. It drives a single slow level line and guarantees that every level change stays put for at least HOLD clock cycles, so a receiver-side filter with a "stable for >9 cycles" threshold never rejects a legitimate change. It sits between a control source, which requests levels over a valid/ready handshake, and an off-chip or cross-module line that ends in the filter.

---
 rtl/hold_tx.sv | 82 ++++++++
 1 files changed

// File: rtl/hold_tx.sv
// Level-line transmitter: forwards requested levels onto o, but keeps every
// transition on the line for at least HOLD cycles so a downstream filter accepts it.
module hold_tx #(
    parameter int HOLD = 12,
    parameter int CW   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       o,
    output logic       busy,
    output logic [7:0] edges
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pendV;
    logic          r_pendB;
    logic          r_o;
    logic [7:0]    r_edges;
    logic          w_accept;

    // The single pending slot can only fill while empty, so it never clashes with a consume.
    assign w_accept = in_valid & ~r_pendV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pendV <= 1'b0;
            r_pendB <= 1'b0;
            r_o     <= 1'b0;
            r_edges <= 8'd0;
        end else begin
            if (w_accept) begin
                r_pendV <= 1'b1;
                r_pendB <= in_bit;
            end
            case (r_state)
                ST_IDLE: begin
                    // A request equal to the current level is consumed without a transition.
                    if (r_pendV) begin
                        r_pendV <= 1'b0;
                        if (r_pendB != r_o) begin
                            r_o     <= r_pendB;
                            r_edges <= r_edges + 8'd1;
                            r_cnt   <= CW'(1);
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign in_ready = ~r_pendV;
    assign o        = r_o;
    assign busy     = (r_state == ST_HOLD) | r_pendV;
    assign edges    = r_edges;

endmodule
